// File: rtl/iq_dbpsk_slicer_if.sv
// Symbol input and word output bus of the DBPSK slicer.
// The master modport is the slicer's side; the slave modport is its surroundings (averagers + FIFO).
interface iq_dbpsk_slicer_if #(
    parameter int NBITS = 32,
    parameter int WBITS = 16
);
    logic signed [NBITS-1:0] avg_i;
    logic signed [NBITS-1:0] avg_q;
    logic                    avg_valid;
    logic [WBITS-1:0]        word_out;
    logic                    word_valid;
    logic                    word_ready;
    logic                    word_erasure;

    modport master (
        input  avg_i, avg_q, avg_valid, word_ready,
        output word_out, word_valid, word_erasure
    );

    modport slave (
        output avg_i, avg_q, avg_valid, word_ready,
        input  word_out, word_valid, word_erasure
    );
endinterface

// File: rtl/iq_dbpsk_slicer.sv
// Differential-BPSK slicer: per-symbol bit decisions, sync-word hunt, word assembly and handoff.
// Define IQ_SLICER_ERASURE_EN to build the low-confidence (erasure) marking; otherwise word_erasure is 0.
module iq_dbpsk_slicer #(
    parameter int               NBITS        = 32,
    parameter int               WBITS        = 16,
    parameter logic [WBITS-1:0] SYNC_WORD    = 16'hB5A3,
    parameter int               FRAME_WORDS  = 8,
    parameter int               ERASE_THRESH = 1000
) (
    input  logic               clk,
    input  logic               rst,
    iq_dbpsk_slicer_if.master  bus,
    output logic               locked,
    output logic               overrun
);
    localparam int PW  = 2 * NBITS;
    localparam int DW  = PW + 1;
    localparam int BCW = $clog2(WBITS);

    if (FRAME_WORDS < 1 || FRAME_WORDS > 255 || ERASE_THRESH < 0 || WBITS < 2) begin : g_bad_param
        $error("iq_dbpsk_slicer: parameter out of range");
    end

    typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

    // Symbol pipeline
    logic signed [NBITS-1:0] prev_i_reg, prev_q_reg;
    logic                    prev_ok_reg;
    logic signed [PW-1:0]    pi_reg, pq_reg;
    logic                    s1_valid_reg;
    logic signed [DW-1:0]    dot;
    logic                    bit_strobe_reg;
    logic                    bit_val_reg;

    // One extra bit of headroom: two products of full-scale negatives overflow PW bits.
    assign dot = DW'(pi_reg) + DW'(pq_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_i_reg     <= '0;
            prev_q_reg     <= '0;
            prev_ok_reg    <= 1'b0;
            pi_reg         <= '0;
            pq_reg         <= '0;
            s1_valid_reg   <= 1'b0;
            bit_strobe_reg <= 1'b0;
            bit_val_reg    <= 1'b0;
        end else begin
            s1_valid_reg   <= bus.avg_valid && prev_ok_reg;
            bit_strobe_reg <= s1_valid_reg;
            if (bus.avg_valid) begin
                pi_reg      <= PW'(bus.avg_i) * PW'(prev_i_reg);
                pq_reg      <= PW'(bus.avg_q) * PW'(prev_q_reg);
                prev_i_reg  <= bus.avg_i;
                prev_q_reg  <= bus.avg_q;
                prev_ok_reg <= 1'b1;
            end
            if (s1_valid_reg) begin
                bit_val_reg <= (dot < 0);
            end
        end
    end

    // Framing state machine
    state_t             state_reg, state_next;
    logic [WBITS-2:0]   sr_reg, sr_next;
    logic [WBITS-1:0]   sr_shift;
    logic [BCW-1:0]     bitcnt_reg, bitcnt_next;
    logic [7:0]         wordcnt_reg, wordcnt_next;
    logic               word_done;
    logic [WBITS-1:0]   word_out_reg;
    logic               word_valid_reg;
    logic               locked_reg, locked_next;
    logic               overrun_reg;
    logic               xfer, load, drop;

    // Only WBITS-1 history bits are kept; the newest bit completes the window.
    assign sr_shift = {sr_reg, bit_val_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= HUNT;
            sr_reg         <= '0;
            bitcnt_reg     <= '0;
            wordcnt_reg    <= '0;
            word_out_reg   <= '0;
            word_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sr_reg      <= sr_next;
            bitcnt_reg  <= bitcnt_next;
            wordcnt_reg <= wordcnt_next;
            locked_reg  <= locked_next;
            if (load) begin
                word_out_reg   <= sr_shift;
                word_valid_reg <= 1'b1;
            end else if (xfer) begin
                word_valid_reg <= 1'b0;
            end
            if (drop) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        sr_next      = sr_reg;
        bitcnt_next  = bitcnt_reg;
        wordcnt_next = wordcnt_reg;
        word_done    = 1'b0;
        if (bit_strobe_reg) begin
            sr_next = sr_shift[WBITS-2:0];
            unique case (state_reg)
                HUNT: begin
                    if (sr_shift == SYNC_WORD) begin
                        state_next   = COLLECT;
                        bitcnt_next  = '0;
                        wordcnt_next = '0;
                    end
                end
                COLLECT: begin
                    if (bitcnt_reg == BCW'(WBITS - 1)) begin
                        word_done    = 1'b1;
                        bitcnt_next  = '0;
                        wordcnt_next = wordcnt_reg + 8'd1;
                        // Clearing history stops the frame tail from matching the sync word.
                        if (wordcnt_reg == 8'(FRAME_WORDS - 1)) begin
                            state_next = HUNT;
                            sr_next    = '0;
                        end
                    end else begin
                        bitcnt_next = bitcnt_reg + BCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        xfer        = word_valid_reg && bus.word_ready;
        load        = word_done && (!word_valid_reg || xfer);
        drop        = word_done && !load;
        locked_next = (state_next == COLLECT);
    end

    assign bus.word_out   = word_out_reg;
    assign bus.word_valid = word_valid_reg;
    assign locked         = locked_reg;
    assign overrun        = overrun_reg;

`ifdef IQ_SLICER_ERASURE_EN
    logic [DW-1:0] dot_mag;
    logic          low_conf_reg;
    logic          erase_flag_reg;
    logic          word_erasure_reg;
    logic          collect_bit;

    assign dot_mag     = dot[DW-1] ? $unsigned(-dot) : $unsigned(dot);
    assign collect_bit = bit_strobe_reg && (state_reg == COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            low_conf_reg     <= 1'b0;
            erase_flag_reg   <= 1'b0;
            word_erasure_reg <= 1'b0;
        end else begin
            if (s1_valid_reg) begin
                low_conf_reg <= (dot_mag < DW'(ERASE_THRESH));
            end
            if (collect_bit) begin
                if (word_done) begin
                    erase_flag_reg <= 1'b0;
                    if (load) begin
                        word_erasure_reg <= erase_flag_reg | low_conf_reg;
                    end
                end else begin
                    erase_flag_reg <= erase_flag_reg | low_conf_reg;
                end
            end
        end
    end

    assign bus.word_erasure = word_erasure_reg;
`else
    assign bus.word_erasure = 1'b0;
`endif
endmodule

// File: tb/tb_iq_dbpsk_slicer.sv
// Self-checking bench for iq_dbpsk_slicer (FRAME_WORDS=2 build); words are checked by a scoreboard.
module tb_iq_dbpsk_slicer;
    localparam logic [15:0] SYNC = 16'hB5A3;
`ifdef IQ_SLICER_ERASURE_EN
    localparam logic ERASE_EXP = 1'b1;
`else
    localparam logic ERASE_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic locked, overrun;
    int   checks = 0;
    int   failures = 0;
    int   phase = 1;
    int   valid_hi_cnt = 0;
    logic [15:0] exp_word_q[$];
    logic        exp_era_q[$];

    iq_dbpsk_slicer_if #(.NBITS(32), .WBITS(16)) bus ();

    iq_dbpsk_slicer #(.FRAME_WORDS(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .locked(locked), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: inputs change 2 units after posedge, so the negedge view is what the next posedge uses.
    always @(negedge clk) begin
        if (bus.word_valid) valid_hi_cnt++;
        if (bus.word_valid && bus.word_ready) begin
            checks++;
            if (exp_word_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: got %h, required no transfer", bus.word_out);
            end else begin
                logic [15:0] ew;
                logic        ee;
                ew = exp_word_q.pop_front();
                ee = exp_era_q.pop_front();
                if (bus.word_out !== ew || bus.word_erasure !== ee) begin
                    failures++;
                    $display("FAIL word_xfer: got %h/era=%b, required %h/era=%b", bus.word_out, bus.word_erasure, ew, ee);
                end else begin
                    $display("xfer word=%h erasure=%b", bus.word_out, bus.word_erasure);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.avg_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        phase = 1;
    endtask

    task automatic send_seed(input int gap);
        bus.avg_i = 32'sd30000;
        bus.avg_q = 32'sd20000;
        bus.avg_valid = 1'b1;
        tick();
        if (gap > 0) begin
            bus.avg_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // MSB-first differential encoding; symbols special-1/special get amplitudes 30/20 with Q=0.
    task automatic send_bits(input logic [31:0] value, input int nbits, input int gap, input int special);
        for (int k = nbits - 1; k >= 0; k--) begin
            int idx;
            int ai;
            int aq;
            idx = nbits - 1 - k;
            ai = int'($urandom_range(50000, 2000));
            aq = int'($urandom_range(50000, 2000));
            if (value[k]) phase = -phase;
            if (idx == special - 1) begin ai = 30; aq = 0; end
            if (idx == special) begin ai = 20; aq = 0; end
            bus.avg_i = 32'(phase * ai);
            bus.avg_q = 32'(phase * aq);
            bus.avg_valid = 1'b1;
            tick();
            if (gap > 0) begin
                bus.avg_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        bus.avg_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic push_word(input logic [15:0] w, input logic e);
        exp_word_q.push_back(w);
        exp_era_q.push_back(e);
    endtask

    task automatic test_reset();
        bus.word_ready = 1'b0;
        bus.avg_valid = 1'b0;
        bus.avg_i = '0;
        bus.avg_q = '0;
        do_reset();
        repeat (20) tick();
        checks++;
        if ({bus.word_out, bus.word_valid, bus.word_erasure, locked, overrun} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs: got out=%h v=%b e=%b l=%b o=%b, required all 0",
                     bus.word_out, bus.word_valid, bus.word_erasure, locked, overrun);
        end
        $display("reset idle outputs out=%h valid=%b locked=%b", bus.word_out, bus.word_valid, locked);
    endtask

    task automatic test_latency();
        int strobes = 0;
        bus.avg_i = 32'sd1000;
        bus.avg_q = 32'sd0;
        bus.avg_valid = 1'b1;
        tick();
        bus.avg_valid = 1'b0;
        repeat (4) begin
            if (dut.bit_strobe_reg) strobes++;
            tick();
        end
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL seed_no_bit: got %0d strobes, required 0", strobes);
        end
        bus.avg_i = -32'sd1000;
        bus.avg_valid = 1'b1;
        tick();
        bus.avg_valid = 1'b0;
        checks++;
        if (dut.bit_strobe_reg !== 1'b0) begin
            failures++;
            $display("FAIL latency_1clk: got strobe=%b, required 0", dut.bit_strobe_reg);
        end
        tick();
        checks++;
        if (dut.bit_strobe_reg !== 1'b1 || dut.bit_val_reg !== 1'b1) begin
            failures++;
            $display("FAIL latency_2clk: got strobe=%b bit=%b, required 1/1", dut.bit_strobe_reg, dut.bit_val_reg);
        end
        tick();
        checks++;
        if (dut.bit_strobe_reg !== 1'b0) begin
            failures++;
            $display("FAIL strobe_width: got strobe=%b, required 0", dut.bit_strobe_reg);
        end
        $display("latency symbol I=-1000 decided bit=%b", dut.bit_val_reg);
    endtask

    task automatic test_wide_dot();
        do_reset();
        bus.avg_i = 32'sh8000_0000;
        bus.avg_q = 32'sh8000_0000;
        bus.avg_valid = 1'b1;
        tick();
        tick();
        bus.avg_valid = 1'b0;
        tick();
        checks++;
        if (dut.bit_strobe_reg !== 1'b1 || dut.bit_val_reg !== 1'b0) begin
            failures++;
            $display("FAIL wide_dot: got strobe=%b bit=%b, required 1/0 (dot=+2^63)", dut.bit_strobe_reg, dut.bit_val_reg);
        end
        $display("wide dot full-scale negatives bit=%b", dut.bit_val_reg);
    endtask

    task automatic test_sync_word();
        do_reset();
        bus.word_ready = 1'b1;
        send_seed(4);
        send_bits({16'd0, SYNC >> 1}, 15, 4, -1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL early_lock: got locked=%b, required 0", locked);
        end
        send_bits({31'd0, SYNC[0]}, 1, 4, -1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL sync_lock: got locked=%b, required 1", locked);
        end
        valid_hi_cnt = 0;
        push_word(16'h1234, 1'b0);
        send_bits({16'd0, 16'h1234}, 16, 4, -1);
        checks++;
        if (valid_hi_cnt != 1) begin
            failures++;
            $display("FAIL valid_width: got %0d cycles, required 1", valid_hi_cnt);
        end
        push_word(16'hBEEF, 1'b0);
        send_bits({16'd0, 16'hBEEF}, 16, 4, -1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL frame_end: got locked=%b, required 0", locked);
        end
        $display("sync word 0x%h then 2 words, locked=%b", SYNC, locked);
    endtask

    task automatic test_sync_anywhere();
        logic [31:0] pre;
        do_reset();
        pre = {27'd0, 5'($urandom())};
        send_seed(4);
        send_bits(pre, 5, 4, -1);
        send_bits({16'd0, SYNC >> 1}, 15, 4, -1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL anywhere_early: got locked=%b, required 0", locked);
        end
        send_bits({31'd0, SYNC[0]}, 1, 4, -1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL anywhere_lock: got locked=%b, required 1", locked);
        end
        $display("sync after prefix %b locked=%b", pre[4:0], locked);
    endtask

    task automatic test_near_miss();
        do_reset();
        send_seed(4);
        send_bits({16'd0, 16'hB5A2}, 16, 4, -1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL near_miss: got locked=%b, required 0", locked);
        end
        $display("near miss 0xB5A2 locked=%b", locked);
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.word_ready = 1'b1;
        send_seed(0);
        push_word(16'hC3C3, 1'b0);
        push_word(16'h0FF0, 1'b0);
        send_bits({SYNC, 16'hC3C3}, 32, 0, -1);
        send_bits({16'd0, 16'h0FF0}, 16, 0, -1);
        checks++;
        if (locked !== 1'b0 || exp_word_q.size() != 0) begin
            failures++;
            $display("FAIL back_to_back: got locked=%b pending=%0d, required 0/0", locked, exp_word_q.size());
        end
        $display("back-to-back symbols, pending words=%0d", exp_word_q.size());
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.word_ready = 1'b0;
        send_seed(4);
        send_bits({SYNC, 16'h1111}, 32, 4, -1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h1111 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL bp_first: got v=%b out=%h ovr=%b, required 1/1111/0", bus.word_valid, bus.word_out, overrun);
        end
        send_bits({16'd0, 16'h2222}, 16, 4, -1);
        checks++;
        if (bus.word_out !== 16'h1111 || overrun !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL bp_overrun: got out=%h ovr=%b lock=%b, required 1111/1/0", bus.word_out, overrun, locked);
        end
        push_word(16'h1111, 1'b0);
        bus.word_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (bus.word_valid !== 1'b0 || exp_word_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: got v=%b pending=%0d, required 0/0", bus.word_valid, exp_word_q.size());
        end
        $display("backpressure overrun=%b word drained", overrun);
    endtask

    task automatic test_erasure();
        do_reset();
        bus.word_ready = 1'b1;
        send_seed(4);
        send_bits({16'd0, SYNC}, 16, 4, -1);
        push_word(16'h1234, ERASE_EXP);
        send_bits({16'd0, 16'h1234}, 16, 4, 5);
        push_word(16'h5678, 1'b0);
        send_bits({16'd0, 16'h5678}, 16, 4, -1);
        $display("erasure words sent, pending=%0d", exp_word_q.size());
    endtask

    task automatic test_reset_midword();
        do_reset();
        checks++;
        if (overrun !== 1'b0 || bus.word_out !== 16'h0000 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_clear: got ovr=%b out=%h lock=%b, required 0/0000/0", overrun, bus.word_out, locked);
        end
        bus.word_ready = 1'b1;
        send_seed(4);
        send_bits({SYNC, 8'h00, 8'h5A}, 24, 4, -1);
        do_reset();
        send_seed(4);
        push_word(16'hA5A5, 1'b0);
        send_bits({SYNC, 16'hA5A5}, 32, 4, -1);
        $display("mid-word reset then fresh word");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wide_dot();
        test_sync_word();
        test_sync_anywhere();
        test_near_miss();
        test_back_to_back();
        test_backpressure();
        test_erasure();
        test_reset_midword();
        repeat (5) tick();
        checks++;
        if (exp_word_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_word_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iq_dbpsk_slicer.md
Name: iq_dbpsk_slicer

Overview:
- Downstream consumer of the I/Q averager pair. Takes one averaged I and one averaged Q value per symbol and makes a differential-BPSK bit decision for each.
- Hunts for a sync word, then assembles the following data bits into words. Hands each word to the packet/CPU side over a valid/ready handshake.
- Sits between the two averager instances, which share `avg_valid`, and the receive FIFO.

Parameters:
- NBITS, 32, width of signed `avg_i` / `avg_q`
- WBITS, 16, bits per output word and width of the sync word
- SYNC_WORD, 16'hB5A3, sync pattern; must be WBITS wide
- FRAME_WORDS, 8, data words collected per sync before re-hunting (1..255)
- ERASE_THRESH, 1000, unsigned magnitude threshold for erasure marking (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- avg_i  in  NBITS  signed averaged I, qualified by `avg_valid`
- avg_q  in  NBITS  signed averaged Q, qualified by `avg_valid`
- avg_valid  in  1  single-cycle strobe, one per symbol
- word_out  out  WBITS  assembled data word, first-received bit in the MSB
- word_valid  out  1  word_out holds a word
- word_ready  in  1  consumer accepts the word
- word_erasure  out  1  word contained at least one low-confidence bit
- locked  out  1  high while in COLLECT
- overrun  out  1  sticky: a completed word was dropped

Behaviour:
- Reset (`rst`=1 at a clk edge):
  - State = HUNT; shift register, bit counter, word counter, prev_i/prev_q, prev_ok, pipeline registers all cleared.
  - Outputs `word_out`=0, `word_valid`=0, `word_erasure`=0, `locked`=0, `overrun`=0.
  - Reset mid-word discards all partial state.
- Symbol pipeline (runs every `avg_valid`, independent of state):
  - S1 (edge after `avg_valid`): register pi = `avg_i`*prev_i and pq = `avg_q`*prev_q, full signed 2*NBITS width. Load prev_i/prev_q with the current inputs. S1 is valid only if prev_ok was 1; then set prev_ok=1.
  - S2 (next edge): dot = pi+pq at 2*NBITS+1 bits, no truncation. bit = 1 if dot<0 (phase reversal), else 0. `bit_strobe` asserts for one cycle.
  - Decision latency: `avg_valid` to `bit_strobe` = 2 clocks.
  - The first symbol after reset only seeds prev and produces no bit.
  - `avg_valid` may assert on consecutive cycles; the pipeline is fully pipelined, with no stall.
- State machine (acts on `bit_strobe`):
  - Shift register update: sr <= {sr[WBITS-2:0], bit}.
  - HUNT: if the updated sr == SYNC_WORD, go to COLLECT with bitcnt=0 and wordcnt=0. Sync detection is on the shifted-in value, so a sync ending on any bit is found.
  - COLLECT: bitcnt increments per bit. On the WBITS-th bit the word is complete, bitcnt returns to 0 and wordcnt increments.
  - When wordcnt reaches FRAME_WORDS, go to HUNT and clear sr to 0, so a stale tail cannot false-sync.
- Output handshake:
  - A transfer occurs when `word_valid` && `word_ready`; `word_valid` then drops next cycle unless a new word loads in the same cycle.
  - A completed word loads into `word_out`, setting `word_valid`=1, if `word_valid`==0 or a transfer occurs in that cycle.
  - Otherwise the new word is dropped and `overrun` sets. `overrun` clears only on `rst`. The dropped word still counts toward FRAME_WORDS.
  - `word_out` and `word_erasure` are stable while `word_valid`=1 and `word_ready`=0.
- `locked` = (state == COLLECT), registered.

Optional Feature:
- Macro: IQ_SLICER_ERASURE_EN.
- Defined:
  - S2 also computes |dot|. A per-word flag is set if any COLLECT bit has |dot| < ERASE_THRESH.
  - The flag is copied to `word_erasure` when the word loads, then cleared for the next word.
  - Erasures do not affect sync detection or the bit value.
- Undefined: `word_erasure` is tied to 0, and no magnitude logic is built.

Test Plan:
- Reset/idle: hold `rst` 3 cycles, then 20 idle cycles -> all outputs 0, `locked`=0.
- Latency: first symbol I=+1000,Q=0, then I=-1000,Q=0 -> no bit for the first symbol; `bit_strobe` exactly 2 clocks after the second `avg_valid`, bit=1.
- Sync + word:
  - Stimulus: seed symbol, then differential symbols encoding 0xB5A3 then 0x1234, with `word_ready`=1 (`avg_valid` every 320 clocks).
  - Required response: `locked` rises after the 16th sync bit; `word_out`=0x1234 with `word_valid` high 1 cycle.
- Sync anywhere: 5 random bits precede 0xB5A3 -> lock on the correct bit; a near-miss 0xB5A2 does not lock.
- Backpressure/overrun: FRAME_WORDS=2, `word_ready`=0, send 0xB5A3,0x1111,0x2222 ->
  - `word_out` holds 0x1111; `overrun`=1 after the second word; state returns to HUNT (`locked`=0).
  - Then `word_ready`=1 -> one transfer of 0x1111.
- Erasure (macro on, ERASE_THRESH=1000): one data symbol with I=20,Q=0 against prev I=30 (dot=600) -> `word_erasure`=1 for that word only. With the macro off -> `word_erasure`=0.
